ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 9, SHALL set the data width of all write and read data paths.
REQ-002 Parameter ADDR_WIDTH, default 15, SHALL set the address width of all address paths.
REQ-003 Parameter MAX_LOCK, default 8, SHALL set the maximum consecutive grants a locking requester holds (range 2..255).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 req_x  input  1  (x = a, b) SHALL be the access request of requester x.
REQ-007 we_x  input  1  SHALL select write (1) or read (0) for requester x.
REQ-008 addr_x  input  ADDR_WIDTH  SHALL be the access address of requester x.
REQ-009 wdata_x  input  DATA_WIDTH  SHALL be the write data of requester x.
REQ-010 lock_x  input  1  SHALL request grant retention for consecutive accesses of requester x.
REQ-011 gnt_x  output  1  SHALL indicate that requester x's access is issued to the RAM this cycle (combinational).
REQ-012 rvalid_x  output  1  SHALL mark rdata_x valid for requester x (registered).
REQ-013 rdata_x  output  DATA_WIDTH  SHALL carry read data to requester x.
REQ-014 ram_we  output  1  SHALL drive the RAM port write enable.
REQ-015 ram_addr  output  ADDR_WIDTH  SHALL drive the RAM port address (read and write use the same address).
REQ-016 ram_wdata  output  DATA_WIDTH  SHALL drive the RAM port write data.
REQ-017 ram_rdata  input  DATA_WIDTH  SHALL be the RAM port registered read data, valid one cycle after the address.

Function
REQ-018 The arbiter SHALL issue at most one access per cycle; gnt_a and gnt_b SHALL never be high together.
REQ-019 The arbiter SHALL implement states IDLE, OWN_A and OWN_B; IDLE arbitrates round-robin using a last-winner pointer.
REQ-020 In IDLE with one req_x high, that requester SHALL be granted the same cycle.
REQ-021 In IDLE with both requests high, the requester other than the last winner SHALL be granted and the pointer SHALL update to it.
REQ-022 A grant with lock_x high SHALL move IDLE to OWN_x and load the lock counter with 1.
REQ-023 In OWN_x, requester x SHALL win whenever req_x is high, and the counter SHALL increment on each such grant.
REQ-024 OWN_x SHALL return to IDLE when lock_x is low, req_x is low, or the counter reaches MAX_LOCK; that cycle's arbitration is performed as from IDLE.
REQ-025 When granted, ram_addr/ram_wdata SHALL equal the winner's addr/wdata and ram_we SHALL equal the winner's we; with no grant, ram_we SHALL be 0.
REQ-026 A granted read SHALL produce rvalid_x high exactly one cycle later, for exactly one cycle, with rdata_x = ram_rdata.
REQ-027 rdata_a and rdata_b SHALL both follow ram_rdata continuously; content is meaningful only while the matching rvalid is high.
REQ-028 A read followed the next cycle by a write to the same address SHALL return the pre-write data.

Reset
REQ-029 While rst_n is low: state = IDLE, pointer = b (so a wins the first tie), counter = 0, rvalid_a = rvalid_b = 0, gnt_a = gnt_b = ram_we = 0.
REQ-030 Reset asserted mid-burst or with a read in flight SHALL abort it; no rvalid SHALL be produced for that read after reset release.

Configuration
REQ-031 With RAM_ARB_LOCK_EN defined, lock_x and states OWN_a/OWN_b SHALL behave per REQ-022..024.
REQ-032 Without RAM_ARB_LOCK_EN, lock_x SHALL be ignored, the counter SHALL be absent, and the arbiter SHALL remain in IDLE (pure round-robin).

Verification
REQ-033 After reset, req_a = req_b = 1, reads at 0x0010/0x0020 -> gnt_a cycle 1, gnt_b cycle 2, alternating; rvalid one cycle after each grant.
REQ-034 req_a write 0x1AB to 0x0005, then read 0x0005 -> rvalid_a with rdata_a = 0x1AB; rvalid_b stays 0.
REQ-035 (RAM_ARB_LOCK_EN) req_a + lock_a held, req_b high, MAX_LOCK = 8 -> 8 consecutive gnt_a, then gnt_b.
REQ-036 Same stimulus without RAM_ARB_LOCK_EN -> strict a/b alternation.
REQ-037 Read granted, rst_n pulsed low before the next edge -> no rvalid; all outputs at reset values.
REQ-038 No requests for 10 cycles -> gnt_a = gnt_b = ram_we = 0 and pointer unchanged.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Signal bundle between two RAM requesters, the arbiter and the single RAM port.
// The slave modport is the arbiter's view; master is the requester/RAM environment.
interface ram_port_arbiter_if #(
   parameter int DATA_WIDTH = 9,
   parameter int ADDR_WIDTH = 15
);
   logic                  req_a;
   logic                  we_a;
   logic [ADDR_WIDTH-1:0] addr_a;
   logic [DATA_WIDTH-1:0] wdata_a;
   logic                  lock_a;
   logic                  gnt_a;
   logic                  rvalid_a;
   logic [DATA_WIDTH-1:0] rdata_a;

   logic                  req_b;
   logic                  we_b;
   logic [ADDR_WIDTH-1:0] addr_b;
   logic [DATA_WIDTH-1:0] wdata_b;
   logic                  lock_b;
   logic                  gnt_b;
   logic                  rvalid_b;
   logic [DATA_WIDTH-1:0] rdata_b;

   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;

   modport slave (
      input  req_a, we_a, addr_a, wdata_a, lock_a,
      input  req_b, we_b, addr_b, wdata_b, lock_b,
      input  ram_rdata,
      output gnt_a, rvalid_a, rdata_a,
      output gnt_b, rvalid_b, rdata_b,
      output ram_we, ram_addr, ram_wdata
   );

   modport master (
      output req_a, we_a, addr_a, wdata_a, lock_a,
      output req_b, we_b, addr_b, wdata_b, lock_b,
      output ram_rdata,
      input  gnt_a, rvalid_a, rdata_a,
      input  gnt_b, rvalid_b, rdata_b,
      input  ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port RAM with registered read data.
// Define RAM_ARB_LOCK_EN to let a requester hold the port for up to MAX_LOCK consecutive grants.
module ram_port_arbiter #(
   parameter int DATA_WIDTH = 9,
   parameter int ADDR_WIDTH = 15,
   parameter int MAX_LOCK   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   ram_port_arbiter_if.slave bus
);

   logic last_b;
   logic pick_a;
   logic pick_b;
   logic hold_a;
   logic hold_b;
   logic gnt_a;
   logic gnt_b;
   logic rvalid_a_q;
   logic rvalid_b_q;

   // Round-robin choice: on a tie the requester that did not win last time goes first.
   always_comb begin
      pick_a = 1'b0;
      pick_b = 1'b0;
      if (bus.req_a && bus.req_b) begin
         pick_a = last_b;
         pick_b = !last_b;
      end else begin
         pick_a = bus.req_a;
         pick_b = bus.req_b;
      end
   end

`ifdef RAM_ARB_LOCK_EN
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OWN_A = 2'd1;
   localparam logic [1:0] OWN_B = 2'd2;

   logic [1:0] state;
   logic [7:0] lock_cnt;
   logic       lock_room;

   assign lock_room = lock_cnt < 8'(MAX_LOCK);
   assign hold_a    = (state == OWN_A) && bus.req_a && bus.lock_a && lock_room;
   assign hold_b    = (state == OWN_B) && bus.req_b && bus.lock_b && lock_room;

   // A burst ends as soon as the owner stops holding; that cycle's winner may start a new one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         lock_cnt <= '0;
      end else if (hold_a || hold_b) begin
         lock_cnt <= lock_cnt + 8'd1;
      end else if (gnt_a && bus.lock_a) begin
         state    <= OWN_A;
         lock_cnt <= 8'd1;
      end else if (gnt_b && bus.lock_b) begin
         state    <= OWN_B;
         lock_cnt <= 8'd1;
      end else begin
         state    <= IDLE;
         lock_cnt <= '0;
      end
   end
`else
   logic [7:0] unused_max_lock;
   logic       unused_lock;

   assign unused_max_lock = 8'(MAX_LOCK);
   assign unused_lock     = bus.lock_a ^ bus.lock_b;
   assign hold_a          = 1'b0;
   assign hold_b          = 1'b0;
`endif

   // Grants are gated by reset so nothing reaches the RAM while rst_n is low.
   assign gnt_a     = rst_n & (hold_a | (~hold_b & pick_a));
   assign gnt_b     = rst_n & (hold_b | (~hold_a & pick_b));
   assign bus.gnt_a = gnt_a;
   assign bus.gnt_b = gnt_b;

   always_comb begin
      bus.ram_we    = 1'b0;
      bus.ram_addr  = bus.addr_a;
      bus.ram_wdata = bus.wdata_a;
      if (gnt_b) begin
         bus.ram_we    = bus.we_b;
         bus.ram_addr  = bus.addr_b;
         bus.ram_wdata = bus.wdata_b;
      end else if (gnt_a) begin
         bus.ram_we = bus.we_a;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_b     <= 1'b1;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
      end else begin
         if (gnt_a) begin
            last_b <= 1'b0;
         end else if (gnt_b) begin
            last_b <= 1'b1;
         end
         rvalid_a_q <= gnt_a & ~bus.we_a;
         rvalid_b_q <= gnt_b & ~bus.we_b;
      end
   end

   assign bus.rvalid_a = rvalid_a_q;
   assign bus.rvalid_b = rvalid_b_q;
   assign bus.rdata_a  = bus.ram_rdata;
   assign bus.rdata_b  = bus.ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter: a behavioural RAM plus a grant/read-data reference model.
module tb_ram_port_arbiter;

   localparam int DW = 9;
   localparam int AW = 15;
   localparam int ML = 8;

   logic clk;
   logic rst_n;

   ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   ram_port_arbiter #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .MAX_LOCK  (ML)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   bit [DW-1:0] ramMem [0:(1<<AW)-1];
   bit [DW-1:0] shadow [0:(1<<AW)-1];

   int          numChecks = 0;
   int          numFails  = 0;
   bit          lockEn;
   int          lastWinner;
   int          owner;
   int          burst;
   bit          pendValid [2];
   logic [DW-1:0] pendData [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment RAM: read-before-write, data registered one cycle after the address.
   always @(posedge clk) begin
      if (bus.ram_we) ramMem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= ramMem[bus.ram_addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numChecks++;
      if (observed !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic resetModel();
      lastWinner   = 1;
      owner        = -1;
      burst        = 0;
      pendValid[0] = 1'b0;
      pendValid[1] = 1'b0;
   endtask

   task automatic driveIdle();
      bus.req_a = 1'b0; bus.we_a = 1'b0; bus.lock_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
      bus.req_b = 1'b0; bus.we_b = 1'b0; bus.lock_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;
   endtask

   // One clock cycle: drive inputs, compare against the model, then advance the model.
   task automatic applyStimulus(input bit ra, input bit wa, input bit la,
                                input logic [AW-1:0] aa, input logic [DW-1:0] da,
                                input bit rb, input bit wb, input bit lb,
                                input logic [AW-1:0] ab, input logic [DW-1:0] db);
      bit            req [2];
      bit            we [2];
      bit            lk [2];
      logic [AW-1:0] ad [2];
      logic [DW-1:0] wd [2];
      int            win;
      bit            holding;
      req[0] = ra; we[0] = wa; lk[0] = la; ad[0] = aa; wd[0] = da;
      req[1] = rb; we[1] = wb; lk[1] = lb; ad[1] = ab; wd[1] = db;
      @(negedge clk);
      bus.req_a = ra; bus.we_a = wa; bus.lock_a = la; bus.addr_a = aa; bus.wdata_a = da;
      bus.req_b = rb; bus.we_b = wb; bus.lock_b = lb; bus.addr_b = ab; bus.wdata_b = db;
      #1;
      win = -1;
      if (lockEn && owner >= 0) begin
         if (req[owner] && lk[owner] && burst < ML) win = owner;
      end
      holding = (win >= 0);
      if (!holding) begin
         if (ra && rb) win = 1 - lastWinner;
         else if (ra) win = 0;
         else if (rb) win = 1;
      end
      checkOutput("gnt_a", 32'(bus.gnt_a), 32'(win == 0));
      checkOutput("gnt_b", 32'(bus.gnt_b), 32'(win == 1));
      if (win >= 0) begin
         checkOutput("ram_we", 32'(bus.ram_we), 32'(we[win]));
         checkOutput("ram_addr", 32'(bus.ram_addr), 32'(ad[win]));
         if (we[win]) checkOutput("ram_wdata", 32'(bus.ram_wdata), 32'(wd[win]));
      end else begin
         checkOutput("ram_we_idle", 32'(bus.ram_we), 32'd0);
      end
      checkOutput("rvalid_a", 32'(bus.rvalid_a), 32'(pendValid[0]));
      checkOutput("rvalid_b", 32'(bus.rvalid_b), 32'(pendValid[1]));
      if (pendValid[0]) checkOutput("rdata_a", 32'(bus.rdata_a), 32'(pendData[0]));
      if (pendValid[1]) checkOutput("rdata_b", 32'(bus.rdata_b), 32'(pendData[1]));

      pendValid[0] = 1'b0;
      pendValid[1] = 1'b0;
      if (win >= 0) begin
         if (we[win]) begin
            shadow[ad[win]] = wd[win];
         end else begin
            pendValid[win] = 1'b1;
            pendData[win]  = shadow[ad[win]];
         end
         lastWinner = win;
         if (holding) begin
            burst++;
         end else if (lockEn && lk[win]) begin
            owner = win;
            burst = 1;
         end else begin
            owner = -1;
            burst = 0;
         end
      end else begin
         owner = -1;
         burst = 0;
      end
   endtask

   task automatic idleCycle();
      applyStimulus(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_gnt_a"}, 32'(bus.gnt_a), 32'd0);
      checkOutput({tag, "_gnt_b"}, 32'(bus.gnt_b), 32'd0);
      checkOutput({tag, "_ram_we"}, 32'(bus.ram_we), 32'd0);
      checkOutput({tag, "_rvalid_a"}, 32'(bus.rvalid_a), 32'd0);
      checkOutput({tag, "_rvalid_b"}, 32'(bus.rvalid_b), 32'd0);
   endtask

   // Full reset with both requesters trying to write, so grant gating is visible.
   task automatic applyReset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_a = 1'b1; bus.we_a = 1'b1;
      bus.req_b = 1'b1; bus.we_b = 1'b1;
      #1;
      checkResetOutputs("rst");
      @(negedge clk);
      checkResetOutputs("rst_hold");
      driveIdle();
      rst_n = 1'b1;
      resetModel();
   endtask

   // Read granted, then rst_n pulsed before the capturing edge: the read must vanish.
   task automatic pulseResetAfterRead();
      applyStimulus(1, 0, 0, 15'h0007, '0, 0, 0, 0, '0, '0);
      #1;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("pulse");
      driveIdle();
      rst_n = 1'b1;
      resetModel();
   endtask

   initial begin
      bit lockHoldA;
      bit lockHoldB;
`ifdef RAM_ARB_LOCK_EN
      lockEn = 1'b1;
`else
      lockEn = 1'b0;
`endif
      rst_n = 1'b0;
      driveIdle();
      resetModel();
      applyReset();

      // Both requesters reading: a first, then strict alternation.
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 15'h0010, '0, 1, 0, 0, 15'h0020, '0);
      idleCycle();

      // Write then read back the same location from a.
      applyStimulus(1, 1, 0, 15'h0005, 9'h1AB, 0, 0, 0, '0, '0);
      applyStimulus(1, 0, 0, 15'h0005, '0, 0, 0, 0, '0, '0);
      idleCycle();
      idleCycle();

      // Read immediately followed by a write to the same address returns old data.
      applyStimulus(0, 0, 0, '0, '0, 1, 0, 0, 15'h0005, '0);
      applyStimulus(0, 0, 0, '0, '0, 1, 1, 0, 15'h0005, 9'h0F3);
      applyStimulus(0, 0, 0, '0, '0, 1, 0, 0, 15'h0005, '0);
      idleCycle();

      // a locking against a steady b request.
      applyReset();
      for (int i = 0; i < 2 * ML + 4; i++) applyStimulus(1, 0, 1, 15'h0010, '0, 1, 0, 0, 15'h0020, '0);
      idleCycle();

      // Long idle stretch, then a tie shows the pointer was left alone.
      applyStimulus(0, 0, 0, '0, '0, 1, 0, 0, 15'h0002, '0);
      for (int i = 0; i < 10; i++) idleCycle();
      applyStimulus(1, 0, 0, 15'h0001, '0, 1, 0, 0, 15'h0002, '0);
      idleCycle();

      pulseResetAfterRead();
      idleCycle();
      applyStimulus(1, 0, 0, 15'h0003, '0, 1, 0, 0, 15'h0004, '0);
      idleCycle();

      lockHoldA = 1'b0;
      lockHoldB = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(7) == 0) lockHoldA = ~lockHoldA;
         if ($urandom_range(7) == 0) lockHoldB = ~lockHoldB;
         applyStimulus($urandom_range(9) < 7, 1'($urandom), lockHoldA,
                       AW'($urandom_range(31)), DW'($urandom),
                       $urandom_range(9) < 7, 1'($urandom), lockHoldB,
                       AW'($urandom_range(31)), DW'($urandom));
      end
      idleCycle();
      idleCycle();

      $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
      $finish;
   end

endmodule
